da_fir_sym_serial: RTL and testbench



---
 rtl/da_fir_pkg.sv | 42 ++++
 rtl/da_fir_sym_serial_if.sv | 43 ++++
 rtl/da_fir_delay_line.sv | 38 +++
 rtl/da_fir_sym_serial.sv | 149 ++++++++++++++
 tb/tb_da_fir_sym_serial.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/da_fir_pkg.sv
// -----------------------------------------------------------------------------
// da_fir_pkg
// Shared definitions for the serial symmetric distributed-arithmetic FIR:
//   - fir_state_t   : controller states (IDLE, PREADD, ACCUM)
//   - DEF_*         : default data/coefficient widths and tap count
//   - half_taps     : number of unique coefficients for a given tap count
//   - coef_addr_w   : width of the coefficient index port
//   - default_out_w : full-precision output width for a parameter set
// No ports; imported by the interface, the delay line and the top module.
// -----------------------------------------------------------------------------
package da_fir_pkg;

    // Controller states of the bit-serial engine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREADD = 2'd1,
        ACCUM  = 2'd2
    } fir_state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_COEF_W = 17;
    localparam int DEF_TAPS   = 20;

    // A symmetric filter only stores one coefficient per tap pair.
    function automatic int half_taps(input int taps);
        return taps / 2;
    endfunction

    function automatic int coef_addr_w(input int taps);
        return $clog2(taps / 2);
    endfunction

    // Pre-add grows the sample by one bit, the product adds COEF_W bits and
    // summing TAPS/2 products adds clog2(TAPS/2) more.
    function automatic int default_out_w(input int data_w, input int coef_w,
                                         input int taps);
        return data_w + 1 + coef_w + $clog2(taps / 2);
    endfunction

    localparam int DEF_OUT_W = default_out_w(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

endpackage

// File: rtl/da_fir_sym_serial_if.sv
// -----------------------------------------------------------------------------
// da_fir_sym_serial_if
// Groups the sample handshake, result and coefficient-write signals of the
// serial symmetric FIR.
//   in_valid/in_ready/in_data : sample input handshake
//   out_valid/out_data        : result pulse and held result
//   coef_we/coef_addr/coef_data/coef_err : coefficient write port
// Modports: master (sample source / host side), slave (filter side).
// -----------------------------------------------------------------------------
interface da_fir_sym_serial_if
    import da_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = default_out_w(DATA_W, COEF_W, TAPS)
);

    localparam int ADDR_W = coef_addr_w(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;

    logic                     out_valid;
    logic signed [OUT_W-1:0]  out_data;

    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_err;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, coef_err
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, coef_err
    );

endinterface

// File: rtl/da_fir_delay_line.sv
// -----------------------------------------------------------------------------
// da_fir_delay_line
// DEPTH-deep signed shift register holding the sample history of the FIR.
//   clk  : clock, rising edge
//   clr  : synchronous clear of every tap
//   en   : shift in din (taps[0] <= din, taps[k] <= taps[k-1])
//   din  : new sample
//   taps : all stored samples, taps[0] newest
// -----------------------------------------------------------------------------
module da_fir_delay_line
    import da_fir_pkg::*;
#(
    parameter int W     = DEF_DATA_W,
    parameter int DEPTH = DEF_TAPS
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] taps [DEPTH]
);

    // The history only moves when a sample is accepted, so taps[k] is always
    // the sample accepted k acceptances ago regardless of idle gaps.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

endmodule

// File: rtl/da_fir_sym_serial.sv
// -----------------------------------------------------------------------------
// da_fir_sym_serial
// Bit-serial symmetric distributed-arithmetic FIR with runtime coefficients.
// y = sum_i coef[i] * (d[i] + d[TAPS-1-i]), one pre-added bit-plane per clock.
//   clk : clock, rising edge
//   rst : synchronous reset, active high; aborts any calculation in flight
//   bus : da_fir_sym_serial_if.slave
//         in_valid/in_ready/in_data : sample accepted only in IDLE
//         out_valid/out_data        : one-cycle pulse, result held afterwards
//         coef_we/coef_addr/coef_data : write honoured only in IDLE, addr<TAPS/2
//         coef_err                  : one-cycle pulse after a rejected write
// One sample per DATA_W+3 clocks.
// -----------------------------------------------------------------------------
module da_fir_sym_serial
    import da_fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = default_out_w(DATA_W, COEF_W, TAPS)
) (
    input logic               clk,
    input logic               rst,
    da_fir_sym_serial_if.slave bus
);

    localparam int HALF   = half_taps(TAPS);
    localparam int ADDR_W = coef_addr_w(TAPS);
    localparam int P_W    = DATA_W + 1;
    localparam int ACC_W  = OUT_W + 1;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    fir_state_t               state;
    logic signed [DATA_W-1:0] d      [TAPS];
    logic signed [COEF_W-1:0] coef   [HALF];
    logic        [P_W-1:0]    p_sr   [HALF];
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  bit_cnt;

    logic signed [ACC_W-1:0]  partial;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     last_bit;
    logic                     accept;
    logic                     coef_ok;

    // A sample is taken whenever the engine is idle and one is offered;
    // in_ready is exactly "state is IDLE", so the state is checked directly.
    // A coefficient write is legal only while idle and for an existing pair.
    always_comb begin
        accept  = (state == IDLE) && bus.in_valid;
        coef_ok = (state == IDLE) &&
                  ({1'b0, bus.coef_addr} < (ADDR_W+1)'(HALF));
    end

    da_fir_delay_line #(
        .W     (DATA_W),
        .DEPTH (TAPS)
    ) u_delay (
        .clk  (clk),
        .clr  (rst),
        .en   (accept),
        .din  (bus.in_data),
        .taps (d)
    );

    // Bit-plane sum: every pair whose current pre-added bit is set contributes
    // its coefficient. The plane is weighted by 2^bit; the final plane is the
    // two's-complement sign bit of the pre-added value and is subtracted.
    // Working at ACC_W keeps the result exact modulo 2^ACC_W.
    always_comb begin
        partial = '0;
        for (int i = 0; i < HALF; i++) begin
            if (p_sr[i][0]) begin
                partial = partial + ACC_W'(coef[i]);
            end
        end
        shifted  = partial <<< bit_cnt;
        last_bit = (bit_cnt == CNT_W'(DATA_W));
        acc_next = last_bit ? (acc - shifted) : (acc + shifted);
    end

    // Controller, coefficient store, pre-adders and accumulator.
    // IDLE waits for a sample (the delay line shifts on the accepting edge),
    // PREADD folds the symmetric taps into DATA_W+1-bit pair sums, and ACCUM
    // walks those sums LSB first for DATA_W+1 clocks before publishing the
    // result. Coefficient writes land in the same edge as a simultaneous
    // accept, so PREADD/ACCUM of that sample already see the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            bit_cnt       <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.coef_err  <= 1'b0;
            for (int i = 0; i < HALF; i++) begin
                coef[i] <= '0;
                p_sr[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.coef_err  <= bus.coef_we && !coef_ok;

            if (bus.coef_we && coef_ok) begin
                coef[bus.coef_addr] <= bus.coef_data;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        state        <= PREADD;
                    end
                end

                PREADD: begin
                    for (int i = 0; i < HALF; i++) begin
                        p_sr[i] <= P_W'(d[i]) + P_W'(d[TAPS-1-i]);
                    end
                    acc     <= '0;
                    bit_cnt <= '0;
                    state   <= ACCUM;
                end

                ACCUM: begin
                    for (int i = 0; i < HALF; i++) begin
                        p_sr[i] <= p_sr[i] >> 1;
                    end
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        bus.out_data  <= acc_next[OUT_W-1:0];
                        bus.out_valid <= 1'b1;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    bus.in_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir_sym_serial.sv
// -----------------------------------------------------------------------------
// tb_da_fir_sym_serial
// Self-checking bench for da_fir_sym_serial. A driver issues samples and
// coefficient writes and pushes the expected result of each accepted sample
// into a queue; a monitor pops and compares whenever out_valid is seen, and
// also checks pulse width, latency and busy time of the handshake.
// -----------------------------------------------------------------------------
module tb_da_fir_sym_serial;
    import da_fir_pkg::*;

    localparam int DATA_W = 12;
    localparam int COEF_W = 17;
    localparam int TAPS   = 20;
    localparam int OUT_W  = default_out_w(DATA_W, COEF_W, TAPS);
    localparam int HALF   = TAPS / 2;
    localparam int ADDR_W = $clog2(HALF);

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic signed [OUT_W-1:0] expQ[$];
    int                      acceptQ[$];
    int                      hist[$];
    int                      modelCoef[HALF];

    int lastAcceptEdge = 0;
    bit prevHold       = 1'b0;
    bit prevOutValid   = 1'b0;
    bit trackReady     = 1'b0;
    int lowCount       = 0;

    da_fir_sym_serial_if #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W)
    ) bus ();

    da_fir_sym_serial #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .OUT_W  (OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and an edge counter used for latency arithmetic.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Reference: direct convolution with the full symmetric impulse response
    // h[k] = coef[min(k, TAPS-1-k)] over the last TAPS accepted samples.
    function automatic void resetModel();
        hist.delete();
        for (int k = 0; k < TAPS; k++) hist.push_back(0);
        for (int i = 0; i < HALF; i++) modelCoef[i] = 0;
    endfunction

    function automatic void modelAccept(input int s);
        longint y;
        logic signed [63:0] yv;
        y = 0;
        hist.push_front(s);
        void'(hist.pop_back());
        for (int k = 0; k < TAPS; k++) begin
            int j;
            j = (k < HALF) ? k : (TAPS - 1 - k);
            y += longint'(modelCoef[j]) * longint'(hist[k]);
        end
        yv = y;
        expQ.push_back(yv[OUT_W-1:0]);
    endfunction

    // Offers one sample and waits for it to be taken. With hold set, in_valid
    // stays high afterwards so back-to-back calls keep the input saturated.
    task automatic applyStimulus(input int s, input bit hold);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(s);
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) begin
            modelAccept(s);
            if (prevHold) checkOutput("accept_period", cyc + 1 - lastAcceptEdge, DATA_W + 3);
            lastAcceptEdge = cyc + 1;
        end else begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        end
        prevHold = hold;
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input int val, input bit expErr);
        bus.coef_we   = 1'b1;
        bus.coef_addr = ADDR_W'(addr);
        bus.coef_data = COEF_W'(val);
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        if (!expErr) modelCoef[addr] = val;
        @(negedge clk);
        checkOutput("coef_err", bus.coef_err, expErr);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("coef_err_pulse", bus.coef_err, 0);
        @(posedge clk);
        #1;
    endtask

    // Write and sample offered in the same idle cycle.
    task automatic acceptWithWrite(input int s, input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = ADDR_W'(addr);
        bus.coef_data = COEF_W'(val);
        bus.in_valid  = 1'b1;
        bus.in_data   = DATA_W'(s);
        @(negedge clk);
        checkOutput("ready_idle", bus.in_ready, 1);
        modelCoef[addr] = val;
        modelAccept(s);
        prevHold = 1'b0;
        @(posedge clk);
        #1;
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("coef_err_same_cycle", bus.coef_err, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        prevHold     = 1'b0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", expQ.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: scoreboard pop on every out_valid plus handshake timing.
    // Acceptance seen before edge E is recorded as edge E; the result must be
    // sampled by edge E+DATA_W+3 and in_ready must read 0 for DATA_W+2 cycles.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            acceptQ.delete();
            trackReady   = 1'b0;
            prevOutValid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                checkOutput("out_valid_width", prevOutValid, 0);
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_out_valid: got out_data=%0d, expected no result", bus.out_data);
                end else begin
                    checkOutput("out_data", bus.out_data, expQ.pop_front());
                end
                if (acceptQ.size() != 0)
                    checkOutput("latency", cyc + 1 - acceptQ.pop_front(), DATA_W + 3);
            end
            if (trackReady) begin
                if (bus.in_ready) begin
                    checkOutput("ready_low_cycles", lowCount, DATA_W + 2);
                    trackReady = 1'b0;
                end else begin
                    lowCount++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acceptQ.push_back(cyc + 1);
                trackReady = 1'b1;
                lowCount   = 0;
            end
            prevOutValid = bus.out_valid;
        end
    end

    // Main stimulus sequence.
    initial begin
        int golden[HALF];
        int runLeft;
        int runVal;
        int s;
        bit hold;

        golden = '{0, 6, 60, 343, 1374, 4124, 9624, 17873, 26810, 32768};
        runLeft = 0;
        runVal  = 0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        resetModel();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_coef_err", bus.coef_err, 0);
        @(posedge clk);
        #1;

        $display("[TB] impulse response with saturated input");
        writeCoef(HALF - 1, 1, 1'b0);
        applyStimulus(100, 1'b1);
        for (int n = 0; n < 19; n++) applyStimulus(0, 1'b1);
        drain();

        $display("[TB] negative full scale");
        for (int i = 0; i < HALF; i++) writeCoef(i, 1, 1'b0);
        for (int n = 0; n < 20; n++) applyStimulus(-2048, 1'b1);
        drain();

        $display("[TB] coefficient write rules");
        applyStimulus(777, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        writeCoef(0, 12345, 1'b1);
        drain();
        writeCoef(HALF, 5, 1'b1);
        acceptWithWrite(-1500, 3, -7000);
        drain();
        applyStimulus(321, 1'b0);
        drain();

        $display("[TB] golden coefficients, random samples");
        for (int i = 0; i < HALF; i++) writeCoef(i, golden[i], 1'b0);
        for (int n = 0; n < 20; n++) applyStimulus(2047, 1'b1);
        for (int n = 0; n < 20; n++) applyStimulus(-2048, 1'b1);
        for (int n = 0; n < 460; n++) begin
            if (runLeft == 0 && $urandom_range(0, 7) == 0) begin
                runLeft = int'($urandom_range(1, 24));
                runVal  = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
            end
            if (runLeft > 0) begin
                s = runVal;
                runLeft--;
            end else begin
                s = int'($urandom_range(0, 4095)) - 2048;
            end
            hold = 1'($urandom_range(0, 1));
            applyStimulus(s, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        $display("[TB] reset during accumulation");
        applyStimulus(1000, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("rst_mid_in_ready", bus.in_ready, 1);
        checkOutput("rst_mid_out_valid", bus.out_valid, 0);
        checkOutput("rst_mid_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        applyStimulus(100, 1'b1);
        for (int n = 0; n < 19; n++) applyStimulus(0, 1'b1);
        drain();
        writeCoef(HALF - 1, 1, 1'b0);
        applyStimulus(100, 1'b1);
        for (int n = 0; n < 19; n++) applyStimulus(0, 1'b1);
        drain();

        checkOutput("leftover_results", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
